// File: rtl/monty_pkg.sv
// Shared definitions for the Montgomery reduction scheduler: width derivations,
// modulus construction and the datapath slot descriptor.
package monty_pkg;

  function automatic int monty_r(input int q_len, input int qh_len);
    return q_len - qh_len;
  endfunction

  // Width of the datapath T output after one R-bit shift of a K-bit product.
  function automatic int monty_cl_len(input int k, input int q_len, input int qh_len);
    return k - monty_r(q_len, qh_len);
  endfunction

  localparam int K_DEF      = 128;
  localparam int Q_LEN_DEF  = 64;
  localparam int QH_LEN_DEF = 26;
  localparam int R_DEF      = monty_r(Q_LEN_DEF, QH_LEN_DEF);
  localparam int CL_LEN_DEF = monty_cl_len(K_DEF, Q_LEN_DEF, QH_LEN_DEF);
  localparam int ITER_DEF   = 2;
  localparam int TAG_W_DEF  = 4;
  localparam int ITER_W     = (ITER_DEF > 1) ? $clog2(ITER_DEF) : 1;

  typedef struct packed {
    logic                 v;
    logic [TAG_W_DEF-1:0] tag;
    logic [ITER_W-1:0]    iter_cnt;
  } slot_t;

  // q = (qH << R) + 1
  function automatic logic [Q_LEN_DEF-1:0] make_q(input logic [QH_LEN_DEF-1:0] qh);
    return (Q_LEN_DEF'(qh) << R_DEF) | Q_LEN_DEF'(1);
  endfunction

endpackage

// File: rtl/monty_out_fifo.sv
// First-word-fall-through result FIFO; output reads zero while empty.
module monty_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign data   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/monty_red_sched.sv
// Iterative Montgomery reduction scheduler: interleaves operations through an
// external fixed-latency word-reduction datapath, then corrects and buffers.
module monty_red_sched
  import monty_pkg::*;
#(
  parameter int K         = K_DEF,
  parameter int Q_LEN     = Q_LEN_DEF,
  parameter int QH_LEN    = QH_LEN_DEF,
  parameter int ITER      = ITER_DEF,
  parameter int PIPE_LAT  = 5,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [QH_LEN-1:0]              cfg_qH,
  output logic                           cfg_err,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [K-1:0]                   in_data,
  input  logic [TAG_W-1:0]               in_tag,
  output logic [QH_LEN-1:0]              dp_qH,
  output logic [K-1:0]                   dp_c,
  input  logic [K-(Q_LEN-QH_LEN)-1:0]    dp_t,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [Q_LEN-1:0]               out_data,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           busy
);

  localparam int R      = monty_r(Q_LEN, QH_LEN);
  localparam int CL_LEN = monty_cl_len(K, Q_LEN, QH_LEN);
  localparam int CR_W   = $clog2(OUT_DEPTH + 1);

  slot_t [PIPE_LAT-1:0]    slots;
  slot_t                   ret, issue;
  logic                    reenter, last_pass, accept, out_hs, cfg_ok;
  logic [CR_W-1:0]         credits;
  logic [QH_LEN-1:0]       qh_r;
  logic [Q_LEN-1:0]        q_val;
  logic                    vld_p1;
  logic [Q_LEN-1:0]        res_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic [Q_LEN+TAG_W-1:0]  fifo_rd;

  function automatic logic [Q_LEN-1:0] cond_sub(input logic [CL_LEN-1:0] t,
                                                input logic [Q_LEN-1:0]  q);
    logic [CL_LEN-1:0] qx, d;
    qx = CL_LEN'(q);
    d  = (t >= qx) ? t - qx : t;
    return d[Q_LEN-1:0];
  endfunction

  assign ret       = slots[PIPE_LAT-1];
  assign reenter   = ret.v && (ret.iter_cnt != ITER_W'(ITER - 1));
  assign last_pass = ret.v && (ret.iter_cnt == ITER_W'(ITER - 1));
  assign in_ready  = rst && !reenter && (credits < CR_W'(OUT_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign busy      = (credits != '0);
  assign cfg_ok    = cfg_we && !busy && !in_valid;
  assign dp_qH     = qh_r;
  assign q_val     = make_q(qh_r);

  // Stage p0: issue into the datapath, returning passes win over new input
  always_comb begin
    issue = '0;
    dp_c  = '0;
    if (reenter) begin
      issue.v        = 1'b1;
      issue.tag      = ret.tag;
      issue.iter_cnt = ret.iter_cnt + ITER_W'(1);
      dp_c           = K'(dp_t);
    end else if (accept) begin
      issue.v   = 1'b1;
      issue.tag = in_tag;
      dp_c      = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots   <= '0;
      credits <= '0;
      qh_r    <= '0;
      cfg_err <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      slots[0] <= issue;
      for (int i = 1; i < PIPE_LAT; i++) slots[i] <= slots[i-1];
      credits <= credits + CR_W'(accept) - CR_W'(out_hs);
      if (cfg_ok) qh_r <= cfg_qH;
      cfg_err <= cfg_we && !cfg_ok;
      vld_p1  <= last_pass;
    end
  end

  // Stage p1: final conditional subtraction of q
  always_ff @(posedge clk) begin
    if (last_pass) begin
      res_p1 <= cond_sub(dp_t, q_val);
      tag_p1 <= ret.tag;
    end
  end

  monty_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (Q_LEN + TAG_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({res_p1, tag_p1}),
    .pop       (out_ready),
    .valid     (out_valid),
    .data      (fifo_rd)
  );

  assign {out_data, out_tag} = fifo_rd;

endmodule

// File: tb/tb_monty_red_sched.sv
// Bench for monty_red_sched: REDC datapath model plus an operation-level
// reference model checked every cycle, with directed literal expectations.
module tb_monty_red_sched;

  localparam int K         = 128;
  localparam int Q_LEN     = 64;
  localparam int QH_LEN    = 26;
  localparam int R         = Q_LEN - QH_LEN;
  localparam int ITER      = 2;
  localparam int PIPE_LAT  = 5;
  localparam int OUT_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int LAT       = ITER * PIPE_LAT + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [QH_LEN-1:0] cfg_qH;
  logic              cfg_err;
  logic              in_valid, in_ready;
  logic [K-1:0]      in_data;
  logic [TAG_W-1:0]  in_tag;
  logic [QH_LEN-1:0] dp_qH;
  logic [K-1:0]      dp_c;
  logic [K-R-1:0]    dp_t;
  logic              out_valid, out_ready;
  logic [Q_LEN-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  monty_red_sched #(
    .K(K), .Q_LEN(Q_LEN), .QH_LEN(QH_LEN), .ITER(ITER),
    .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_qH(cfg_qH), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .dp_qH(dp_qH), .dp_c(dp_c), .dp_t(dp_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One REDC word step: T = (C + m*q) / 2^R with m = -C mod 2^R
  function automatic logic [K-R-1:0] dp_f(input logic [K-1:0] c, input logic [QH_LEN-1:0] qh);
    logic [255:0] qq, m, s, mask;
    mask = (256'd1 << R) - 256'd1;
    qq   = (256'(qh) << R) + 256'd1;
    m    = ((256'd1 << R) - (256'(c) & mask)) & mask;
    s    = 256'(c) + m * qq;
    return s[R +: (K-R)];
  endfunction

  function automatic logic [Q_LEN-1:0] ref_red(input logic [K-1:0] c, input logic [QH_LEN-1:0] qh);
    logic [K-1:0]   x;
    logic [K-R-1:0] t, q;
    x = c;
    t = '0;
    for (int i = 0; i < ITER; i++) begin
      t = dp_f(x, qh);
      x = K'(t);
    end
    q = ((K-R)'(qh) << R) | (K-R)'(1);
    if (t >= q) t = t - q;
    return t[Q_LEN-1:0];
  endfunction

  // External datapath: dp_t presents f(dp_c) PIPE_LAT cycles later
  logic [K-R-1:0] pipe [PIPE_LAT];
  initial for (int i = 0; i < PIPE_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    for (int i = PIPE_LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= dp_f(dp_c, dp_qH);
  end
  assign dp_t = pipe[PIPE_LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [Q_LEN-1:0] d;
    logic [TAG_W-1:0] t;
    int               rdy;
  } op_t;

  op_t               q_m[$];
  bit                reent[int];
  logic [QH_LEN-1:0] qh_m = '0;
  bit                err_m = 1'b0;
  bit                ir_e, ov_e, busy_e;
  op_t               op;

  // Reference model: every op occupies a credit from accept to pop, returns to
  // the datapath every PIPE_LAT cycles and is visible LAT cycles after accept.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst cfg_err", cfg_err, 0);
      chk("rst dp_c", dp_c, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_tag", out_tag, 0);
      chk("rst dp_qH", dp_qH, 0);
      q_m.delete();
      reent.delete();
      qh_m  = '0;
      err_m = 1'b0;
    end else begin
      busy_e = (q_m.size() != 0);
      ir_e   = !reent.exists(cyc) && (q_m.size() < OUT_DEPTH);
      ov_e   = busy_e && (q_m[0].rdy <= cyc);
      chk("in_ready", in_ready, ir_e);
      chk("out_valid", out_valid, ov_e);
      chk("busy", busy, busy_e);
      chk("cfg_err", cfg_err, err_m);
      chk("dp_qH", dp_qH, qh_m);
      if (reent.exists(cyc)) reent.delete(cyc);
      if (out_valid && out_ready && q_m.size() != 0) begin
        chk("out_data", out_data, q_m[0].d);
        chk("out_tag", out_tag, q_m[0].t);
        void'(q_m.pop_front());
      end
      if (in_valid && in_ready) begin
        op.d   = ref_red(in_data, qh_m);
        op.t   = in_tag;
        op.rdy = cyc + LAT;
        q_m.push_back(op);
        for (int j = 1; j < ITER; j++) reent[cyc + j * PIPE_LAT] = 1'b1;
      end
      err_m = cfg_we && (busy_e || in_valid);
      if (cfg_we && !busy_e && !in_valid) qh_m = cfg_qH;
    end
  end

  function automatic logic [K-1:0] rnd_c();
    logic [K-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    v[K-1] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [QH_LEN-1:0] v);
    cfg_we = 1'b1;
    cfg_qH = v;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg idle dp_qH", dp_qH, v);
    tick();
  endtask

  task automatic send(input logic [K-1:0] c, input logic [TAG_W-1:0] tg, output int acc);
    in_valid = 1'b1;
    in_data  = c;
    in_tag   = tg;
    acc      = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("send timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int oc, output logic [Q_LEN-1:0] d, output logic [TAG_W-1:0] t);
    oc = -1;
    d  = '0;
    t  = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        oc = cyc;
        d  = out_data;
        t  = out_tag;
        break;
      end
    end
    if (oc < 0) chk("wait_out timeout", 0, 1);
    tick();
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle timeout", 0, 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, oc, n;
    logic [Q_LEN-1:0] od;
    logic [TAG_W-1:0] ot;
    logic [K-1:0]     qv;
    qv = (K'(1) << R) + K'(1);
    rst = 1'b0; cfg_we = 1'b0; cfg_qH = '0;
    in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    cfg(26'd1);

    send(K'(5) << (2 * R), 4'd3, acc);
    wait_out(oc, od, ot);
    chk("basic latency", oc - acc, 12);
    chk("basic data", od, 5);
    chk("basic tag", ot, 3);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = rnd_c();
      in_tag   = TAG_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = rnd_c();
      in_tag   = TAG_W'(i);
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    chk("bp accepts", acc, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) n++;
      tick();
    end
    chk("bp drained", n, 4);
    chk("bp busy after drain", busy, 0);

    send(qv << (2 * R), 4'd1, acc);
    wait_out(oc, od, ot);
    chk("corr T==q", od, 0);
    send((qv - K'(1)) << (2 * R), 4'd2, acc);
    wait_out(oc, od, ot);
    chk("corr T==q-1", od, 64'h40_0000_0000);
    wait_idle();

    send(K'(7) << (2 * R), 4'd5, acc);
    cfg_we = 1'b1;
    cfg_qH = 26'h3f;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg busy err", cfg_err, 1);
    chk("cfg busy dp_qH", dp_qH, 1);
    tick();
    wait_out(oc, od, ot);
    chk("cfg busy result", od, 7);
    wait_idle();
    cfg(26'h15);

    cfg(QH_LEN'($urandom));
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rnd_c();
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_qH    = QH_LEN'($urandom);
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    wait_idle();

    cfg(26'd1);
    send(rnd_c(), 4'd10, acc);
    send(rnd_c(), 4'd11, acc);
    send(rnd_c(), 4'd12, acc);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    cfg(26'd1);
    send(K'(9) << (2 * R), 4'd6, acc);
    wait_out(oc, od, ot);
    chk("post-rst latency", oc - acc, 12);
    chk("post-rst data", od, 9);
    chk("post-rst tag", ot, 6);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monty_red_sched.md
# monty_red_sched

Iterative scheduler for the word-level Montgomery reduction pipeline. It accepts K-bit products and passes each one ITER times through an external fixed-latency word-reduction datapath. Several operations are interleaved in the datapath's pipeline slots. After the last pass it applies the final conditional subtraction of q and buffers results behind a valid/ready output. It sits between the modular multiplier's product stage and the consumer of reduced operands.

## Interface
- K, 128, product width
- Q_LEN, 64, modulus width; q = (qH << R) + 1
- QH_LEN, 26, width of qH
- R, Q_LEN-QH_LEN, bits removed per pass
- ITER, 2, passes per operation (ITER ≥ 1; total shift ITER·R)
- PIPE_LAT, 5, datapath latency in cycles, C to T
- OUT_DEPTH, 4, output FIFO depth (≥ 2)
- TAG_W, 4, user tag width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  load cfg_qH
- cfg_qH  in  QH_LEN  modulus high part
- cfg_err  out  1  one-cycle pulse when cfg_we is rejected
- in_valid / in_ready  in/out  1  product handshake
- in_data  in  K  product C
- in_tag  in  TAG_W  tag, returned unchanged
- dp_qH  out  QH_LEN  registered qH, to the datapath
- dp_c  out  K  datapath C input
- dp_t  in  K-R  datapath T output; valid PIPE_LAT cycles after dp_c
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  Q_LEN  reduced result, < q
- out_tag  out  TAG_W  tag of the result
- busy  out  1  any operation in flight or buffered

## Operation
- **Slot tracker.** A shift register of PIPE_LAT entries tracks the datapath's slots. Each entry is {v, tag, iter_cnt}. Entry 0 is loaded together with dp_c. Entry PIPE_LAT-1 lines up with dp_t.
- **Return, passes remaining.** A returning entry with iter_cnt < ITER-1 re-enters the datapath: dp_c = zero-extended dp_t, iter_cnt+1. Re-entry has priority over new input. in_ready is low in that cycle.
- **Return, last pass.** A returning entry with iter_cnt = ITER-1 goes to the correction register: res = (dp_t ≥ q) ? dp_t − q : dp_t, truncated to Q_LEN. It is then pushed into the FIFO.
- **Credits.** A credit counter tracks in-flight + correction + FIFO occupancy and never exceeds OUT_DEPTH.
  - in_ready = rst_deasserted & no re-entry this cycle & credits < OUT_DEPTH.
  - The counter increments on accept and decrements on out handshake. Both in one cycle leave it unchanged.
- **Idle slots.** If no entry is issued, dp_c holds 0 and the slot is not valid.
- **Configuration.** cfg_we is accepted only when busy = 0 and in_valid = 0; qH is then loaded on the next edge. Otherwise qH is unchanged and cfg_err pulses for one cycle.
- **Reset.** Asserting rst at any time discards every in-flight and buffered operation. Reset values:
  - all outputs low: out_valid, in_ready, busy, cfg_err
  - dp_c = 0, out_data = 0, out_tag = 0
  - qH = 0, credits = 0, all slot valids = 0

## Timing
- **Latency without contention:** accept to out_valid = ITER·PIPE_LAT + 2 cycles (1 correction register + 1 FIFO write). Default: 12.
- **Throughput:** one accept per cycle, except in cycles with a re-entry.
- **Sustained rate:** at most 1/ITER per cycle, bounded by OUT_DEPTH / latency when out_ready is held high.
- **Output:** out_data/out_tag are stable while out_valid=1 & out_ready=0. The FIFO is first-word-fall-through.
- **Ordering:** completion order equals accept order, since all operations take the same path length.
- **Full FIFO:** no overflow is possible because of the credit rule. A full FIFO with out_ready=0 stalls input only; the datapath keeps draining into the FIFO.
- **ITER = 1:** re-entry never occurs and in_ready depends on credits only.

## Structure
- Package monty_pkg holds:
  - the R and CL_LEN derivation
  - the q construction function
  - a slot typedef {v, tag, iter_cnt}, with iter_cnt width $clog2(ITER)
- Sub-module monty_out_fifo: parameterised FWFT FIFO, depth OUT_DEPTH, width Q_LEN+TAG_W, asynchronous active-low reset.
- The datapath is instantiated by the parent, outside this block.

## Test plan
- **Basic reduction.** Defaults, qH=1, so R=38 and q=2^38+1. Input C=5·2^76 with tag 3 gives out_data=5, out_tag=3, exactly 12 cycles after accept.
- **Back-to-back input.** Drive in_valid with out_ready=1. in_ready shows the 1/2 pattern and results come out in order with matching tags.
- **Backpressure.** Hold out_ready=0. Exactly 4 accepts occur, then in_ready stays low. Releasing out_ready drains 4 results without loss.
- **Correction boundary.** A C whose final T equals q gives out_data=0. A C with final T = q−1 gives q−1, with no subtraction.
- **Configuration while busy.** Assert cfg_we while busy=1: cfg_err pulses and dp_qH is unchanged. Assert it when idle: dp_qH updates next cycle.
- **Reset mid-operation.** Assert rst with 3 operations in flight. All outputs take their reset values, and after release the first new accept completes at 12 cycles.
